// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory fetch port: fault codes and the read-pipeline stage record.
package imem_pkg;

  localparam int IMEM_MAX_LATENCY = 4;
  localparam int IMEM_ADDR_W      = 32;
  localparam int IMEM_DATA_W      = 32;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_t;

  typedef struct packed {
    logic                   valid;
    logic [IMEM_DATA_W-1:0] instr;
    logic [IMEM_ADDR_W-1:0] addr;
    fault_t                 fault;
  } stage_t;

endpackage

// File: rtl/imem_read_pipe.sv
// Read pipeline: LATENCY stage registers shifting together on adv; async clear, sync flush drops valid bits.
// Flush takes priority over advance, so a stalled output is also discarded.
module imem_read_pipe
  import imem_pkg::*;
#(
  parameter int     LATENCY   = 1,
  parameter stage_t RST_STAGE = '0
) (
  input  logic   clock,
  input  logic   clear,
  input  logic   flush,
  input  logic   adv,
  input  stage_t in_stage,
  output stage_t out_stage
);

  stage_t stage_q [LATENCY];
  stage_t stage_d [LATENCY];

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      for (int k = 0; k < LATENCY; k++) stage_d[k].valid = 1'b0;
    end else if (adv) begin
      stage_d[0] = in_stage;
      for (int k = 1; k < LATENCY; k++) stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= RST_STAGE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_stage = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with valid/ready fetch port, range/alignment fault codes and a READ_LATENCY-stage read pipe.
// Optional load port (ld_*) enabled by defining IMEM_LOAD_PORT_EN; default build is read-only.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                ADDR_W       = IMEM_ADDR_W,
  parameter int                DATA_W       = IMEM_DATA_W,
  parameter int                DEPTH        = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0040_0000,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0,
  parameter string             INIT_FILE    = ""
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_instr,
  output logic [ADDR_W-1:0]         rsp_addr,
  output logic [1:0]                rsp_fault
`ifdef IMEM_LOAD_PORT_EN
  ,
  input  logic                      ld_en,
  input  logic [$clog2(DEPTH)-1:0]  ld_index,
  input  logic [DATA_W-1:0]         ld_data
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 4);
  // Out-of-range latencies are clamped into the supported 1..IMEM_MAX_LATENCY window.
  localparam int PIPE_LAT = (READ_LATENCY < 1) ? 1 :
                            (READ_LATENCY > IMEM_MAX_LATENCY) ? IMEM_MAX_LATENCY : READ_LATENCY;
  localparam stage_t RST_STAGE = '{valid: 1'b0, instr: NOP_WORD, addr: '0, fault: FAULT_OK};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              adv;
  logic              accept;
  fault_t            fault;
  stage_t            in_stage;
  stage_t            out_stage;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

`ifdef IMEM_LOAD_PORT_EN
  // The read into stage 0 samples the old word on the same edge, giving read-before-write.
  always @(posedge clock) begin
    if (ld_en) mem_q[ld_index] <= ld_data;
  end
`endif

  assign adv       = !(out_stage.valid && !rsp_ready);
  assign req_ready = adv && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    offset   = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);
    fault    = FAULT_OK;
    if (!in_range) begin
      fault = FAULT_RANGE;
    end else if (req_addr[1:0] != 2'b00) begin
      fault = FAULT_MISALIGN;
    end
    in_stage.valid = accept;
    in_stage.addr  = req_addr;
    in_stage.fault = fault;
    in_stage.instr = (fault == FAULT_OK) ? mem_q[offset[IDX_W+1:2]] : NOP_WORD;
  end

  imem_read_pipe #(
    .LATENCY   (PIPE_LAT),
    .RST_STAGE (RST_STAGE)
  ) u_pipe (
    .clock     (clock),
    .clear     (clear),
    .flush     (flush),
    .adv       (adv),
    .in_stage  (in_stage),
    .out_stage (out_stage)
  );

  assign rsp_valid = out_stage.valid;
  assign rsp_instr = out_stage.instr;
  assign rsp_addr  = out_stage.addr;
  assign rsp_fault = out_stage.fault;

endmodule
